result_capture_display: RTL and testbench

- Sits directly downstream of the logical unit on the DE10-Lite board.
- Takes the unit's 9-bit result bus and a raw active-low pushbutton, then debounces the button.
- On each press it snapshots the result into a 4-deep history.
- Drives three active-low seven-segment digits showing the selected history entry in hex.

---
 rtl/result_capture_display.sv | 148 ++++++++++++++
 tb/tb_result_capture_display.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_capture_display.sv
// result_capture_display
// Debounces an active-low capture pushbutton, snapshots the 9-bit logical-unit
// result on each press into a small history, and shows the selected entry in
// hex on three active-low seven-segment digits.
//
// Build option: define RESULT_HISTORY_EN to keep a 4-deep history selectable
// by `view`. Without it only the newest capture is kept and `view` is ignored.

module result_capture_display #(
  parameter int DB_CYCLES = 500000,
  parameter int DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] lOut,
  input  logic       key_n,
  input  logic [1:0] view,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       valid,
  output logic [3:0] cap_cnt
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [6:0] DASH = 7'b0111111;

  logic          sync1;
  logic          ks;
  logic          db;
  logic          db_prev;
  logic [CW-1:0] db_cnt;
  logic          strobe;

  logic [8:0]       entry [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [IW-1:0] sel;
  logic [8:0]    sel_entry;

  // Standard hex-to-segment patterns, bit0 = a .. bit6 = g, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Two-flop synchronizer for the asynchronous pushbutton; idles released (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      ks    <= 1'b1;
    end else begin
      sync1 <= key_n;
      ks    <= sync1;
    end
  end

  // Debounce: the level only follows ks after it has differed for DB_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db     <= 1'b1;
      db_cnt <= '0;
    end else if (ks == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db     <= ks;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  // Delayed copy of the debounced level so a press yields a one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= 1'b1;
    end else begin
      db_prev <= db;
    end
  end

  assign strobe = db_prev & ~db;

  // History capture: newest result enters slot 0, older ones age toward DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
      ent_valid <= '0;
      cap_cnt   <= 4'd0;
    end else if (strobe) begin
`ifdef RESULT_HISTORY_EN
      for (int i = DEPTH - 1; i > 0; i--) begin
        entry[i] <= entry[i-1];
      end
      ent_valid <= {ent_valid[DEPTH-2:0], 1'b1};
`else
      ent_valid[0] <= 1'b1;
`endif
      entry[0] <= lOut;
      cap_cnt  <= cap_cnt + 4'd1;
    end
  end

`ifdef RESULT_HISTORY_EN
  assign sel = IW'(view);
`else
  logic unused_view;
  assign unused_view = ^view;
  assign sel = '0;
`endif

  // Display path: purely combinational so a view change shows immediately.
  always_comb begin
    sel_entry = entry[sel];
    valid     = ent_valid[sel];
    HEX0      = DASH;
    HEX1      = DASH;
    HEX2      = DASH;
    if (valid) begin
      HEX0 = hex7(sel_entry[3:0]);
      HEX1 = hex7(sel_entry[7:4]);
      HEX2 = hex7({3'b000, sel_entry[8]});
    end
  end

endmodule

// File: tb/tb_result_capture_display.sv
// tb_result_capture_display
// Self-checking bench for result_capture_display with a short debounce window.
// A behavioural model (sample queue, run-length debounce, history queue) is
// compared against the outputs after every clock edge, alongside hand-written
// sequences and a table of display vectors.

`timescale 1ns/1ps

module tb_result_capture_display;

  localparam int DB = 4;
  localparam logic [6:0] DASH = 7'b0111111;
`ifdef RESULT_HISTORY_EN
  localparam int HIST_DEPTH = 4;
`else
  localparam int HIST_DEPTH = 1;
`endif

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [8:0] value;
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] lOut;
  logic       key_n;
  logic [1:0] view;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic       valid;
  logic [3:0] cap_cnt;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  // Behavioural model state
  logic       key_q [$] = '{1'b1, 1'b1};
  logic [8:0] m_hist [$];
  int         m_total = 0;
  logic       m_db = 1'b1;
  int         m_run = 0;
  bit         m_cap_next = 0;

  result_capture_display #(.DB_CYCLES(DB), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .lOut(lOut),
    .key_n(key_n),
    .view(view),
    .HEX0(HEX0),
    .HEX1(HEX1),
    .HEX2(HEX2),
    .valid(valid),
    .cap_cnt(cap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic s;
    if (rst) begin
      m_hist.delete();
      m_total    = 0;
      m_db       = 1'b1;
      m_run      = 0;
      m_cap_next = 0;
      key_q      = '{1'b1, 1'b1};
    end else begin
      s = key_q[0];
      if (m_cap_next) begin
        m_hist.push_front(lOut);
        if (m_hist.size() > HIST_DEPTH) void'(m_hist.pop_back());
        m_total++;
      end
      m_cap_next = 0;
      if (s != m_db) begin
        m_run++;
        if (m_run == DB) begin
          m_db       = s;
          m_run      = 0;
          m_cap_next = (s == 1'b0);
        end
      end else begin
        m_run = 0;
      end
      key_q.push_back(key_n);
      if (key_q.size() > 2) void'(key_q.pop_front());
    end
  endtask

  // Per-edge comparison of every output against the model.
  initial begin
    int idx;
    logic [8:0] v;
    logic [6:0] e0, e1, e2;
    logic ev;
    forever begin
      @(posedge clk);
      #1;
      model_step();
      if (check_en) begin
        idx = (HIST_DEPTH == 4) ? int'(view) : 0;
        e0 = DASH; e1 = DASH; e2 = DASH; ev = 1'b0;
        if (idx < m_hist.size()) begin
          v  = m_hist[idx];
          ev = 1'b1;
          e0 = SEG[v[3:0]];
          e1 = SEG[v[7:4]];
          e2 = SEG[{3'b000, v[8]}];
        end
        check_output("model_outputs", {5'd0, HEX2, HEX1, HEX0, valid, cap_cnt},
                     {5'd0, e2, e1, e0, ev, 4'(m_total % 16)});
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic key, input logic [8:0] lval, input logic [1:0] vw);
    @(negedge clk);
    key_n = key;
    lOut  = lval;
    view  = vw;
  endtask

  task automatic press(input logic [8:0] value);
    apply_stimulus(1'b0, value, view);
    wait_edges(DB + 6);
    apply_stimulus(1'b1, value, view);
    wait_edges(DB + 6);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t vecs [6];
    logic [6:0] exp_h0;

    vecs[0] = '{9'h1A5, 7'b1111001, 7'b0001000, 7'b0010010};
    vecs[1] = '{9'h0FF, 7'b1000000, 7'b0001110, 7'b0001110};
    vecs[2] = '{9'h13C, 7'b1111001, 7'b0110000, 7'b1000110};
    vecs[3] = '{9'h0E9, 7'b1000000, 7'b0000110, 7'b0010000};
    vecs[4] = '{9'h1D7, 7'b1111001, 7'b0100001, 7'b1111000};
    vecs[5] = '{9'h16B, 7'b1111001, 7'b0000010, 7'b0000011};

    rst = 1'b1; key_n = 1'b1; lOut = 9'h000; view = 2'd0;
    check_en = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_hex0", HEX0, DASH);
    check_output("reset_hex1", HEX1, DASH);
    check_output("reset_hex2", HEX2, DASH);
    check_output("reset_valid", valid, 1'b0);
    check_output("reset_cap_cnt", cap_cnt, 4'd0);
    rst = 1'b0;

    // Single press held 20 cycles: capture exactly at edge k+6
    apply_stimulus(1'b0, 9'h1A5, 2'd0);
    wait_edges(6);
    check_output("press_before_due", cap_cnt, 4'd0);
    wait_edges(1);
    check_output("press_at_due", cap_cnt, 4'd1);
    check_output("press_hex2", HEX2, 7'b1111001);
    check_output("press_hex1", HEX1, 7'b0001000);
    check_output("press_hex0", HEX0, 7'b0010010);
    check_output("press_valid", valid, 1'b1);
    wait_edges(13);
    check_output("press_held_once", cap_cnt, 4'd1);
    apply_stimulus(1'b1, 9'h1A5, 2'd0);
    wait_edges(DB + 6);

    // Short glitches are ignored
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 9'h1A5, 2'd0);
      wait_edges(3);
      apply_stimulus(1'b1, 9'h1A5, 2'd0);
      wait_edges(3);
    end
    wait_edges(DB + 4);
    check_output("glitch_no_capture", cap_cnt, 4'd1);

    // Five captures in sequence
    for (int i = 1; i <= 5; i++) press(9'(i));
    apply_stimulus(1'b1, 9'h005, 2'd0);
    #1;
    check_output("seq_view0_hex0", HEX0, 7'b0010010);
    check_output("seq_view0_hex2", HEX2, 7'b1000000);
    @(negedge clk);
    view = 2'd3;
    #1;
    exp_h0 = (HIST_DEPTH == 4) ? 7'b0100100 : 7'b0010010;
    check_output("seq_view3_hex0", HEX0, exp_h0);
    check_output("seq_view3_valid", valid, 1'b1);
    apply_stimulus(1'b1, 9'h0FF, 2'd3);
    wait_edges(5);
    check_output("seq_lout_change_hex0", HEX0, exp_h0);
    check_output("seq_lout_change_hex1", HEX1, 7'b1000000);
    check_output("seq_cap_cnt", cap_cnt, 4'd6);

    // Table of display vectors
    foreach (vecs[i]) begin
      press(vecs[i].value);
      apply_stimulus(1'b1, vecs[i].value, 2'd0);
      #1;
      check_output("table_hex2", HEX2, vecs[i].h2);
      check_output("table_hex1", HEX1, vecs[i].h1);
      check_output("table_hex0", HEX0, vecs[i].h0);
      check_output("table_valid", valid, 1'b1);
    end

    // Partially filled history, then wrap of the capture counter
    do_reset(2);
    press(9'h011);
    press(9'h022);
    apply_stimulus(1'b1, 9'h000, 2'd2);
    #1;
    check_output("partial_view2_valid", valid, (HIST_DEPTH == 4) ? 1'b0 : 1'b1);
    check_output("partial_view2_hex0", HEX0, (HIST_DEPTH == 4) ? DASH : 7'b0100100);
    for (int i = 0; i < 14; i++) press(9'(i));
    check_output("wrap_cap_cnt", cap_cnt, 4'd0);

    // Reset in the middle of a debounce window with the key held low
    do_reset(2);
    apply_stimulus(1'b0, 9'h155, 2'd0);
    wait_edges(4);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_edges(1);
    check_output("midreset_orig_due", cap_cnt, 4'd0);
    wait_edges(DB + 1);
    check_output("midreset_before_due", cap_cnt, 4'd0);
    wait_edges(1);
    check_output("midreset_capture", cap_cnt, 4'd1);
    check_output("midreset_hex1", HEX1, 7'b0010010);
    apply_stimulus(1'b1, 9'h155, 2'd0);
    wait_edges(DB + 6);

    // Reset during the strobe cycle wins
    do_reset(2);
    apply_stimulus(1'b0, 9'h0AA, 2'd0);
    wait_edges(6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    key_n = 1'b1;
    #1;
    check_output("strobe_reset_cnt", cap_cnt, 4'd0);
    check_output("strobe_reset_valid", valid, 1'b0);
    wait_edges(DB + 6);
    check_output("strobe_reset_after", cap_cnt, 4'd0);

    // Randomized stimulus, checked by the model on every edge
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(1);
      end
      apply_stimulus(1'($urandom_range(0, 1)), 9'($urandom), 2'($urandom_range(0, 3)));
      wait_edges($urandom_range(1, DB + 4));
    end

    wait_edges(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
